// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding and lamp codes shared by the intersection scheduler.
package traffic_pkg;
  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALL_RED = 2'd2, WALK = 2'd3} phase_t;
  localparam logic [2:0] LAMP_G = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b001;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: round-robin pick of the first request after last, scanning last+1, last+2, ... mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] nxt,
  output logic       vld
);
  always_comb begin
    nxt = last;
    for (int i = 4; i >= 1; i--) if (req[2'(int'(last) + i)]) nxt = 2'(int'(last) + i);
  end
  assign vld = |req;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: four-approach GREEN/YELLOW/ALL_RED sequencer with round-robin handover.
// Define PED_CROSSING_EN to add the ped_req/walk ports and the WALK phase.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 80,
  parameter int YELLOW_T  = 20,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 30,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  has_car,
`ifdef PED_CROSSING_EN
  input  logic        ped_req,
  output logic        walk,
`endif
  output logic [11:0] lights,
  output logic [1:0]  owner,
  output logic [1:0]  phase
);
  localparam logic [CNT_W-1:0] MG = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] YT = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] AT = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] WT = CNT_W'(WALK_T);
  phase_t phase_q, phase_d;
  logic [1:0] owner_q, owner_d, nxt_q, nxt_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic [3:0] other;
  logic pick_vld, done;
`ifdef PED_CROSSING_EN
  logic ped_q, ped_d;
`endif
  assign other = has_car & ~(4'b0001 << owner_q);
  rr_pick4 u_pick (.req(other), .last(owner_q), .nxt(pick), .vld(pick_vld));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= GREEN;
      owner_q <= 2'd0;
      nxt_q   <= 2'd0;
      cnt_q   <= CNT_W'(1);
`ifdef PED_CROSSING_EN
      ped_q   <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      owner_q <= owner_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
`ifdef PED_CROSSING_EN
      ped_q   <= ped_d;
`endif
    end
  end
  always_comb begin
    lim = phase_q == GREEN ? MG : phase_q == YELLOW ? YT : phase_q == ALL_RED ? AT : WT;
    done = cnt_q >= lim;
    phase_d = phase_q;
    owner_d = owner_q;
    nxt_d = nxt_q;
    case (phase_q)
      GREEN: if (done && pick_vld) begin
        phase_d = YELLOW;
        nxt_d = pick;
      end
      YELLOW: if (done) phase_d = ALL_RED;
      ALL_RED: if (done) begin
`ifdef PED_CROSSING_EN
        phase_d = ped_q ? WALK : GREEN;
        owner_d = ped_q ? owner_q : nxt_q;
`else
        phase_d = GREEN;
        owner_d = nxt_q;
`endif
      end
      default: if (done) begin
        phase_d = GREEN;
        owner_d = nxt_q;
      end
    endcase
    // every phase entry restarts the saturating counter at 1
    cnt_d = phase_d != phase_q ? CNT_W'(1) : done ? cnt_q : cnt_q + 1'b1;
`ifdef PED_CROSSING_EN
    ped_d = (ped_q | ped_req) & ~(phase_d == WALK && phase_q != WALK);
`endif
  end
  always_comb begin
    for (int i = 0; i < 4; i++)
      lights[3*i+:3] = owner_q != 2'(i) ? LAMP_R : phase_q == GREEN ? LAMP_G : phase_q == YELLOW ? LAMP_Y : LAMP_R;
    owner = owner_q;
    phase = phase_q;
`ifdef PED_CROSSING_EN
    walk = phase_q == WALK;
`endif
  end
endmodule
